// File: rtl/lif_stdp_net.sv
`default_nettype none
// ============================================================================
// lif_stdp_net : NUM_PRE LIF neurons driving one LIF neuron, pair-based STDP
// Rev 1.0
// ============================================================================
module lif_stdp_net #(
   parameter int NUM_PRE     = 2,
   parameter int STATE_W     = 8,
   parameter int CUR_W       = 8,
   parameter int W_W         = 8,
   parameter int THRESH      = 128,
   parameter int DECAY_SHIFT = 2,
   parameter int REFRAC      = 2,
   parameter int W_INIT      = 64,
   parameter int A_PLUS      = 4,
   parameter int A_MINUS     = 4,
   parameter int WINDOW      = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_PRE*CUR_W-1:0] cur_in,
   input  logic [CUR_W-1:0]         post_cur_in,
   input  logic                     learn_en,
   input  logic                     w_clear,
   output logic [NUM_PRE-1:0]       pre_spike,
   output logic                     post_spike,
   output logic [STATE_W-1:0]       post_state,
   output logic [NUM_PRE*W_W-1:0]   weights
);
   localparam int RF_W  = $clog2(REFRAC + 2);
   localparam int AGE_W = $clog2(WINDOW + 2);
   localparam int SUM_W = STATE_W + W_W + 4;
   localparam logic [STATE_W+1:0] c_state_max = {2'b00, {STATE_W{1'b1}}};
   localparam logic [STATE_W+1:0] c_thresh    = (STATE_W+2)'(THRESH);
   localparam logic [RF_W-1:0]    c_refrac    = RF_W'(REFRAC);
   localparam logic [AGE_W-1:0]   c_window    = AGE_W'(WINDOW);
   localparam logic [W_W-1:0]     c_w_max     = {W_W{1'b1}};
   localparam logic [W_W-1:0]     c_w_init    = W_W'(W_INIT);

   function automatic logic [STATE_W+1:0] f_integrate(input logic [STATE_W-1:0] st,
                                                      input logic [STATE_W-1:0] cur);
      logic [STATE_W+1:0] sum;
      sum = {2'b00, st} - {2'b00, (st >> DECAY_SHIFT)} + {2'b00, cur};
      return (sum > c_state_max) ? c_state_max : sum;
   endfunction

   // Spike age saturates at the window edge so "not recent" is a single value
   function automatic logic [AGE_W-1:0] f_age(input logic spike, input logic [AGE_W-1:0] age);
      if (spike) return '0;
      return (age >= c_window) ? c_window : age + AGE_W'(1);
   endfunction

   logic [SUM_W-1:0]   w_post_sum;
   logic [STATE_W-1:0] w_post_cur;
   logic [STATE_W+1:0] w_post_nxt;
   logic [RF_W-1:0]    r_post_refrac;
   logic [AGE_W-1:0]   r_post_age;

   always_comb begin
      w_post_sum = SUM_W'(post_cur_in);
      for (int i = 0; i < NUM_PRE; i++) begin
         if (pre_spike[i]) w_post_sum = w_post_sum + SUM_W'(weights[i*W_W +: W_W]);
      end
   end

   assign w_post_cur = (w_post_sum > SUM_W'(c_state_max)) ? {STATE_W{1'b1}} : w_post_sum[STATE_W-1:0];
   assign w_post_nxt = f_integrate(post_state, w_post_cur);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         post_state    <= '0;
         post_spike    <= 1'b0;
         r_post_refrac <= '0;
         r_post_age    <= c_window;
      end else begin
         r_post_age <= f_age(post_spike, r_post_age);
         if (r_post_refrac != '0) begin
            r_post_refrac <= r_post_refrac - RF_W'(1);
            post_state    <= '0;
            post_spike    <= 1'b0;
         end else if (w_post_nxt >= c_thresh) begin
            r_post_refrac <= c_refrac;
            post_state    <= '0;
            post_spike    <= 1'b1;
         end else begin
            post_state    <= w_post_nxt[STATE_W-1:0];
            post_spike    <= 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_pre
      logic [STATE_W-1:0] r_state;
      logic [RF_W-1:0]    r_refrac;
      logic               r_spike;
      logic [AGE_W-1:0]   r_age;
      logic [W_W-1:0]     r_weight;
      logic [STATE_W+1:0] w_nxt;
      logic [W_W:0]       w_up;
      logic [W_W-1:0]     w_plus;
      logic [W_W-1:0]     w_minus;
      logic               w_pot;
      logic               w_dep;

      assign w_nxt = f_integrate(r_state, STATE_W'(cur_in[gi*CUR_W +: CUR_W]));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_state  <= '0;
            r_refrac <= '0;
            r_spike  <= 1'b0;
            r_age    <= c_window;
         end else begin
            r_age <= f_age(r_spike, r_age);
            if (r_refrac != '0) begin
               r_refrac <= r_refrac - RF_W'(1);
               r_state  <= '0;
               r_spike  <= 1'b0;
            end else if (w_nxt >= c_thresh) begin
               r_refrac <= c_refrac;
               r_state  <= '0;
               r_spike  <= 1'b1;
            end else begin
               r_state  <= w_nxt[STATE_W-1:0];
               r_spike  <= 1'b0;
            end
         end
      end

      // Coincident pre/post spikes fall into the potentiation branch only
      assign w_pot   = post_spike && (r_spike || (r_age < c_window));
      assign w_dep   = r_spike && !post_spike && (r_post_age < c_window);
      assign w_up    = {1'b0, r_weight} + (W_W+1)'(A_PLUS);
      assign w_plus  = (w_up > {1'b0, c_w_max}) ? c_w_max : w_up[W_W-1:0];
      assign w_minus = ({1'b0, r_weight} < (W_W+1)'(A_MINUS)) ? '0 : r_weight - W_W'(A_MINUS);

      always_ff @(posedge clk or posedge rst) begin
         if (rst)                    r_weight <= c_w_init;
         else if (w_clear)           r_weight <= c_w_init;
         else if (learn_en && w_pot) r_weight <= w_plus;
         else if (learn_en && w_dep) r_weight <= w_minus;
      end

      assign pre_spike[gi]             = r_spike;
      assign weights[gi*W_W +: W_W]    = r_weight;
   end

endmodule
`default_nettype wire

// File: tb/tb_lif_stdp_net.sv
`default_nettype none
// ============================================================================
// tb_lif_stdp_net : vector table, directed corner sequences and random traffic
// checked against an integer reference model. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lif_stdp_net;
   localparam int NP = 2, CW = 8, SW = 8, WW = 8;
   localparam int THR = 128, DS = 2, RF = 2, WI = 64, AP = 4, AM = 4, WIN = 15;
   localparam int SMAX = 255, WMAX = 255;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NP*CW-1:0] cur_in = '0;
   logic [CW-1:0]    post_cur_in = '0;
   logic             learn_en = 1'b0;
   logic             w_clear = 1'b0;
   logic [NP-1:0]    pre_spike, pre_spike_lo;
   logic             post_spike, post_spike_lo;
   logic [SW-1:0]    post_state, post_state_lo;
   logic [NP*WW-1:0] weights, weights_lo;

   int checks = 0, failures = 0;

   lif_stdp_net dut (
      .clk(clk), .rst(rst), .cur_in(cur_in), .post_cur_in(post_cur_in),
      .learn_en(learn_en), .w_clear(w_clear), .pre_spike(pre_spike),
      .post_spike(post_spike), .post_state(post_state), .weights(weights));

   lif_stdp_net #(.W_INIT(2)) dut_lo (
      .clk(clk), .rst(rst), .cur_in(cur_in), .post_cur_in(post_cur_in),
      .learn_en(learn_en), .w_clear(w_clear), .pre_spike(pre_spike_lo),
      .post_spike(post_spike_lo), .post_state(post_state_lo), .weights(weights_lo));

   always #5 clk = ~clk;

   // Reference model state (plain integers)
   int m_pst[NP], m_prf[NP], m_pspk[NP], m_page[NP], m_w[NP];
   int m_st, m_rf, m_spk, m_age;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_pst[i] = 0; m_prf[i] = 0; m_pspk[i] = 0; m_page[i] = WIN; m_w[i] = WI;
      end
      m_st = 0; m_rf = 0; m_spk = 0; m_age = WIN;
   endtask

   task automatic lif(input int st, input int rf, input int cur,
                      output int nst, output int nrf, output int nspk);
      int v;
      if (rf != 0) begin
         nst = 0; nrf = rf - 1; nspk = 0;
      end else begin
         v = st - st / (1 << DS) + cur;
         if (v > SMAX) v = SMAX;
         if (v >= THR) begin nst = 0; nrf = RF; nspk = 1; end
         else begin nst = v; nrf = 0; nspk = 0; end
      end
   endtask

   task automatic model_step();
      int n_pst[NP], n_prf[NP], n_pspk[NP], n_page[NP], n_w[NP];
      int pc, n_st, n_rf, n_spk;
      pc = int'(post_cur_in);
      for (int i = 0; i < NP; i++) if (m_pspk[i] != 0) pc += m_w[i];
      if (pc > SMAX) pc = SMAX;
      for (int i = 0; i < NP; i++) begin
         lif(m_pst[i], m_prf[i], int'(cur_in[i*CW +: CW]), n_pst[i], n_prf[i], n_pspk[i]);
         n_page[i] = (m_pspk[i] != 0) ? 0 : ((m_page[i] + 1 > WIN) ? WIN : m_page[i] + 1);
         n_w[i] = m_w[i];
         if (w_clear) n_w[i] = WI;
         else if (learn_en) begin
            if (m_spk != 0 && (m_pspk[i] != 0 || m_page[i] < WIN))
               n_w[i] = (m_w[i] + AP > WMAX) ? WMAX : m_w[i] + AP;
            else if (m_pspk[i] != 0 && m_spk == 0 && m_age < WIN)
               n_w[i] = (m_w[i] - AM < 0) ? 0 : m_w[i] - AM;
         end
      end
      lif(m_st, m_rf, pc, n_st, n_rf, n_spk);
      m_age = (m_spk != 0) ? 0 : ((m_age + 1 > WIN) ? WIN : m_age + 1);
      m_st = n_st; m_rf = n_rf; m_spk = n_spk;
      for (int i = 0; i < NP; i++) begin
         m_pst[i] = n_pst[i]; m_prf[i] = n_prf[i]; m_pspk[i] = n_pspk[i];
         m_page[i] = n_page[i]; m_w[i] = n_w[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [NP-1:0]    ep;
      logic [NP*WW-1:0] ew;
      for (int i = 0; i < NP; i++) begin
         ep[i] = (m_pspk[i] != 0);
         ew[i*WW +: WW] = WW'(m_w[i]);
      end
      check({tag, "_pre"}, 32'(pre_spike), 32'(ep));
      check({tag, "_post"}, 32'(post_spike), 32'(m_spk));
      check({tag, "_state"}, 32'(post_state), 32'(m_st));
      check({tag, "_w"}, 32'(weights), 32'(ew));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic set_in(input int c0, input int c1, input int pc, input logic le);
      cur_in = {CW'(c1), CW'(c0)};
      post_cur_in = CW'(pc);
      learn_en = le;
   endtask

   typedef struct {
      bit rst_first;
      int cur0, cur1, pcur;
      bit learn;
      int e_pre, e_post, e_state, e_w0, e_w1;
   } vec_t;

   vec_t tbl[16];

   initial begin
      #100000000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      // single pre channel driven: period-3 firing, post integrates 64 per pre spike
      tbl[0]  = '{1, 200, 0, 0, 0, 1, 0,   0, 64, 64};
      tbl[1]  = '{0, 200, 0, 0, 0, 0, 0,  64, 64, 64};
      tbl[2]  = '{0, 200, 0, 0, 0, 0, 0,  48, 64, 64};
      tbl[3]  = '{0, 200, 0, 0, 0, 1, 0,  36, 64, 64};
      tbl[4]  = '{0, 200, 0, 0, 0, 0, 0,  91, 64, 64};
      tbl[5]  = '{0, 200, 0, 0, 0, 0, 0,  69, 64, 64};
      tbl[6]  = '{0, 200, 0, 0, 0, 1, 0,  52, 64, 64};
      tbl[7]  = '{0, 200, 0, 0, 0, 0, 0, 103, 64, 64};
      tbl[8]  = '{0, 200, 0, 0, 0, 0, 0,  78, 64, 64};
      tbl[9]  = '{0, 200, 0, 0, 0, 1, 0,  59, 64, 64};
      // both channels driven, learning off: post fires one cycle after each pre pair
      tbl[10] = '{1, 200, 200, 0, 0, 3, 0, 0, 64, 64};
      tbl[11] = '{0, 200, 200, 0, 0, 0, 1, 0, 64, 64};
      tbl[12] = '{0, 200, 200, 0, 0, 0, 0, 0, 64, 64};
      tbl[13] = '{0, 200, 200, 0, 0, 3, 0, 0, 64, 64};
      tbl[14] = '{0, 200, 200, 0, 0, 0, 1, 0, 64, 64};
      tbl[15] = '{0, 200, 200, 0, 0, 0, 0, 0, 64, 64};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("rst_w", 32'(weights), 32'h4040);
      check("rst_state", 32'(post_state), 32'd0);

      for (int r = 0; r < 16; r++) begin
         if (tbl[r].rst_first) begin
            set_in(0, 0, 0, 1'b0);
            w_clear = 1'b0;
            do_reset();
         end
         set_in(tbl[r].cur0, tbl[r].cur1, tbl[r].pcur, tbl[r].learn);
         tick();
         check($sformatf("tbl%0d_pre", r), 32'(pre_spike), 32'(tbl[r].e_pre));
         check($sformatf("tbl%0d_post", r), 32'(post_spike), 32'(tbl[r].e_post));
         check($sformatf("tbl%0d_state", r), 32'(post_state), 32'(tbl[r].e_state));
         check($sformatf("tbl%0d_w", r), 32'(weights), 32'({WW'(tbl[r].e_w1), WW'(tbl[r].e_w0)}));
      end

      // Mid-run asynchronous reset with spiking activity
      do_reset();
      set_in(200, 200, 200, 1'b1);
      for (int k = 0; k < 7; k++) begin tick(); check_model("act"); end
      rst = 1'b1;
      #1;
      check("arst_pre", 32'(pre_spike), 32'd0);
      check("arst_post", 32'(post_spike), 32'd0);
      check("arst_state", 32'(post_state), 32'd0);
      check("arst_w", 32'(weights), 32'h4040);
      check("arst_wlo", 32'(weights_lo), 32'h0202);
      set_in(0, 0, 0, 1'b0);
      #1;
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 5; k++) begin
         tick();
         check("idle_pre", 32'(pre_spike), 32'd0);
         check("idle_post", 32'(post_spike), 32'd0);
         check("idle_w", 32'(weights), 32'h4040);
      end

      // Scenario with coincident pre spikes and learning: follow the model
      do_reset();
      set_in(200, 200, 0, 1'b1);
      for (int k = 0; k < 30; k++) begin tick(); check_model("pair"); end

      // Pre and post fire together every 3 cycles: pure potentiation up to clamp
      do_reset();
      set_in(200, 200, 200, 1'b1);
      for (int k = 0; k < 150; k++) begin tick(); check_model("clamp"); end
      check("clamp_w", 32'(weights), 32'hFFFF);
      for (int k = 0; k < 6; k++) tick();
      check("clamp_hold", 32'(weights), 32'hFFFF);

      // Depression: pre fires shortly after a lone post spike
      do_reset();
      set_in(0, 0, 200, 1'b1);
      tick(); check("dep_post", 32'(post_spike), 32'd1);
      set_in(0, 0, 0, 1'b1);
      tick(); check_model("dep1");
      set_in(200, 0, 0, 1'b1);
      tick(); check("dep_pre", 32'(pre_spike), 32'd1);
      set_in(0, 0, 0, 1'b1);
      tick();
      check("dep_w", 32'(weights), 32'h403C);
      check("dep_wlo", 32'(weights_lo), 32'h0200);
      for (int k = 0; k < 4; k++) begin tick(); check_model("dep_after"); end

      // Window edge: pre spike 15 cycles after post depresses, 16 cycles does not
      for (int g = 14; g <= 15; g++) begin
         do_reset();
         set_in(0, 0, 200, 1'b1);
         tick();
         set_in(0, 0, 0, 1'b1);
         for (int k = 0; k < g; k++) tick();
         set_in(200, 0, 0, 1'b1);
         tick();
         set_in(0, 0, 0, 1'b1);
         tick();
         check($sformatf("win%0d_w", g), 32'(weights), (g == 14) ? 32'h403C : 32'h4040);
         check_model($sformatf("win%0d", g));
      end

      // w_clear on a post-spike edge wins over potentiation
      do_reset();
      set_in(200, 200, 200, 1'b1);
      for (int k = 0; k < 7; k++) tick();
      for (int k = 0; k < 4 && post_spike !== 1'b1; k++) tick();
      check("clr_post", 32'(post_spike), 32'd1);
      check("clr_pre_w", 32'(weights), 32'h4848);
      w_clear = 1'b1;
      tick();
      check("clr_w", 32'(weights), 32'h4040);
      check_model("clr");
      w_clear = 1'b0;
      tick();
      check_model("clr_next");

      // Random traffic against the model
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         set_in($urandom_range(0, 150), $urandom_range(0, 150), $urandom_range(0, 90),
                ($urandom_range(0, 9) != 0));
         w_clear = ($urandom_range(0, 99) == 0);
         tick();
         check_model("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
